data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal array, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, range 1..15: extra latency cycles, used only when DMEM_WAIT_STATES_EN is defined.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port reqValid, input, 1: memory-stage request present.
REQ-006 SHALL have port reqReady, output, 1: responder can accept a request.
REQ-007 SHALL have port reqAddress, input, 32: byte address.
REQ-008 SHALL have port reqWrite, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port reqWidth, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 SHALL have port reqSigned, input, 1: sign-extend load data.
REQ-011 SHALL have port reqStoreData, input, 32: store data, LSB-aligned.
REQ-012 SHALL have port rspValid, output, 1: response present.
REQ-013 SHALL have port rspReady, input, 1: requester accepts the response.
REQ-014 SHALL have port rspData, output, 32: extended load data; 0 for stores and faults.
REQ-015 SHALL have port rspFault, output, 1: request rejected (misaligned, out of range or illegal width).

Function
REQ-016 SHALL implement FSM IDLE -> (WAIT) -> RESP -> IDLE; reqReady = 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle where reqValid && reqReady, latch all req* fields and ignore req* inputs until back in IDLE.
REQ-018 SHALL leave IDLE for RESP on the edge after acceptance when DMEM_WAIT_STATES_EN is undefined, so rspValid rises exactly 1 cycle after acceptance.
REQ-019 SHALL hold rspValid, rspData and rspFault stable in RESP until rspReady = 1, then return to IDLE on that edge; no new request is accepted in the same cycle.
REQ-020 SHALL flag a fault when any of these hold: half access with address[0] = 1; word access with address[1:0] != 0; reqWidth = 11; address[31:2] >= DEPTH_WORDS.
REQ-021 SHALL commit a non-faulting store on the edge that enters RESP, updating only the byte lanes selected by width and address[1:0]; a faulting store writes nothing.
REQ-022 SHALL form load data by selecting the addressed byte or half from the word, then zero-extending or sign-extending it per reqSigned; word loads pass through unchanged.
REQ-023 SHALL return rspData = 0 for stores and for faulting requests.
REQ-024 SHALL use array index address[log2(DEPTH_WORDS)+1:2]; address bits above this range never wrap, they fault per REQ-020.

Reset
REQ-025 SHALL force state = IDLE, reqReady = 1 after release, rspValid = 0, rspData = 0, rspFault = 0 and the wait counter = 0 while reset = 1.
REQ-026 SHALL discard an in-flight request on reset in WAIT or RESP; a store not yet committed is lost, and a committed store persists.
REQ-027 SHALL NOT reset array contents; they are undefined until first written.

Configuration
REQ-028 SHALL, when macro DMEM_WAIT_STATES_EN is defined, insert state WAIT between IDLE and RESP with a counter loaded to WAIT_CYCLES and decremented each cycle, entering RESP when it reaches 0, so rspValid rises WAIT_CYCLES + 1 cycles after acceptance.
REQ-029 SHALL, when DMEM_WAIT_STATES_EN is undefined, contain no WAIT state and no counter logic, and ignore WAIT_CYCLES.

Verification
REQ-030 SHALL cover: word store 0xDEADBEEF @0x10, then byte load signed @0x13 -> rspData 0xFFFFFFDE, rspFault 0; the same load unsigned -> 0x000000DE.
REQ-031 SHALL cover: half store 0x8001 @0x22 over word 0x11223344 @0x20, then word load @0x20 -> 0x80013344.
REQ-032 SHALL cover: word load @0x06 and half store @0x05 -> rspFault 1, rspData 0, memory unchanged; address 0x1000 with DEPTH_WORDS = 1024 -> rspFault 1.
REQ-033 SHALL cover: rspReady held 0 for 5 cycles in RESP -> rspValid and rspData stable, reqReady 0, and a reqValid pulse ignored.
REQ-034 SHALL cover: with DMEM_WAIT_STATES_EN defined and WAIT_CYCLES = 3 -> rspValid 4 cycles after acceptance; reset asserted in WAIT during a store of 0xA5 -> a later load returns the old value.
REQ-035 SHALL cover: back-to-back requests with rspReady tied 1 -> one request accepted every 2 cycles with no DMEM_WAIT_STATES_EN.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-port data-memory responder for a pipeline memory stage: one request in flight,
// byte/half/word access with load extension. Optional wait states via DMEM_WAIT_STATES_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddress,
    input  logic        reqWrite,
    input  logic [1:0]  reqWidth,
    input  logic        reqSigned,
    input  logic [31:0] reqStoreData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        rspFault
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef DMEM_WAIT_STATES_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RESP} state_t;
`endif

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_fault_q;
    logic        fault_q;
    logic        write_q;
    logic [1:0]  width_q;
    logic        signed_q;
    logic [1:0]  addr_lo_q;

    logic        in_fault;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    logic          iss_en;
    logic          iss_we;
    logic [AW-1:0] iss_idx;
    logic [3:0]    iss_be;
    logic [31:0]   iss_wdata;

    logic [31:0] rd_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data_d;

    // Decode of the live request: lane enables, replicated store data and fault.
    always_comb begin
        in_be    = 4'b0000;
        in_wdata = 32'h0;
        case (reqWidth)
            2'b00: begin
                in_be    = 4'b0001 << reqAddress[1:0];
                in_wdata = {4{reqStoreData[7:0]}};
            end
            2'b01: begin
                in_be    = reqAddress[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{reqStoreData[15:0]}};
            end
            2'b10: begin
                in_be    = 4'b1111;
                in_wdata = reqStoreData;
            end
            default: ;
        endcase
        in_fault = (reqWidth == 2'b11)
                 | ((reqWidth == 2'b01) & reqAddress[0])
                 | ((reqWidth == 2'b10) & (|reqAddress[1:0]))
                 | ({2'b00, reqAddress[31:2]} >= 32'(DEPTH_WORDS));
    end

`ifdef DMEM_WAIT_STATES_EN
    logic [3:0]    wait_cnt_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;

    // The array is accessed on the edge that leaves WAIT, so it works from latched fields.
    assign iss_en    = (state_q == ST_WAIT) && (wait_cnt_q == 4'd1);
    assign iss_we    = iss_en && write_q && !fault_q;
    assign iss_idx   = idx_q;
    assign iss_be    = be_q;
    assign iss_wdata = wdata_q;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^WAIT_CYCLES;

    // Without wait states the array is accessed on the acceptance edge itself.
    assign iss_en    = (state_q == ST_IDLE) && reqValid;
    assign iss_we    = iss_en && reqWrite && !in_fault;
    assign iss_idx   = reqAddress[AW+1:2];
    assign iss_be    = in_be;
    assign iss_wdata = in_wdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            fault_q     <= 1'b0;
            write_q     <= 1'b0;
            width_q     <= 2'b00;
            signed_q    <= 1'b0;
            addr_lo_q   <= 2'b00;
`ifdef DMEM_WAIT_STATES_EN
            wait_cnt_q  <= 4'd0;
            idx_q       <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (reqValid) begin
                        req_ready_q <= 1'b0;
                        fault_q     <= in_fault;
                        write_q     <= reqWrite;
                        width_q     <= reqWidth;
                        signed_q    <= reqSigned;
                        addr_lo_q   <= reqAddress[1:0];
`ifdef DMEM_WAIT_STATES_EN
                        idx_q       <= reqAddress[AW+1:2];
                        be_q        <= in_be;
                        wdata_q     <= in_wdata;
                        wait_cnt_q  <= 4'(WAIT_CYCLES);
                        state_q     <= ST_WAIT;
`else
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= in_fault;
                        state_q     <= ST_RESP;
`endif
                    end
                end
`ifdef DMEM_WAIT_STATES_EN
                ST_WAIT: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= fault_q;
                        state_q     <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (rspReady) begin
                        rsp_valid_q <= 1'b0;
                        rsp_fault_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // One byte-wide block RAM per lane; the read register only moves on an issue edge,
    // which keeps rspData stable for the whole RESP state.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            always_ff @(posedge clk) begin
                if (iss_en) begin
                    if (iss_we && iss_be[gi]) begin
                        lane_mem[iss_idx] <= iss_wdata[gi*8 +: 8];
                    end
                    rd_byte_q <= lane_mem[iss_idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    always_comb begin
        sel_byte    = rd_word[{addr_lo_q, 3'b000} +: 8];
        sel_half    = addr_lo_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_data_d = 32'h0;
        case (width_q)
            2'b00:   load_data_d = {{24{signed_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_data_d = {{16{signed_q & sel_half[15]}}, sel_half};
            2'b10:   load_data_d = rd_word;
            default: load_data_d = 32'h0;
        endcase
    end

    assign reqReady = req_ready_q;
    assign rspValid = rsp_valid_q;
    assign rspFault = rsp_fault_q;
    assign rspData  = (rsp_valid_q && !rsp_fault_q && !write_q) ? load_data_d : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed vectors, hold/backpressure,
// back-to-back throughput, reset during a transaction and a short random run.
module tb_data_mem_responder;

    localparam int WAITC = 3;
`ifdef DMEM_WAIT_STATES_EN
    localparam int EXP_LAT = WAITC + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddress;
    logic        reqWrite;
    logic [1:0]  reqWidth;
    logic        reqSigned;
    logic [31:0] reqStoreData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspFault;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_data_q [$];
    logic        exp_fault_q [$];
    logic [7:0]  mdl [int unsigned];

    data_mem_responder #(
        .DEPTH_WORDS(1024),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddress  (reqAddress),
        .reqWrite    (reqWrite),
        .reqWidth    (reqWidth),
        .reqSigned   (reqSigned),
        .reqStoreData(reqStoreData),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspData     (rspData),
        .rspFault    (rspFault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [1:0] w, input logic sg);
        logic [31:0] r;
        r = 32'h0;
        case (w)
            2'b00: r = sg ? {{24{mdl[a][7]}}, mdl[a]} : {24'h0, mdl[a]};
            2'b01: r = sg ? {{16{mdl[a+1][7]}}, mdl[a+1], mdl[a]} : {16'h0, mdl[a+1], mdl[a]};
            2'b10: r = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic void mdl_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] sd);
        int n;
        n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mdl[a + 32'(k)] = sd[k*8 +: 8];
    endfunction

    // One request/response; 'hold' cycles of rspReady=0 in RESP with an ignored reqValid pulse.
    task automatic xact(input logic wr, input logic [1:0] w, input logic sg, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] ed, input logic ef, input int hold);
        int lat;
        logic [31:0] d0;
        exp_data_q.push_back(ed);
        exp_fault_q.push_back(ef);
        @(negedge clk);
        check_eq("req_ready_idle", 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = wr; reqWidth = w; reqSigned = sg;
        reqAddress = a; reqStoreData = sd;
        @(posedge clk); #1;
        reqValid = 1'b0;
        reqAddress = $urandom; reqStoreData = $urandom;
        reqWidth = 2'($urandom); reqWrite = 1'($urandom); reqSigned = 1'($urandom);
        lat = 1;
        while (!rspValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(EXP_LAT));
        check_eq("req_ready_busy", 32'(reqReady), 32'd0);
        d0 = rspData;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                reqValid = 1'b1; reqWrite = 1'b1; reqWidth = 2'b10;
                reqAddress = 32'h200; reqStoreData = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            reqValid = 1'b0;
            check_eq("hold_valid", 32'(rspValid), 32'd1);
            check_eq("hold_data", rspData, d0);
            check_eq("hold_ready", 32'(reqReady), 32'd0);
        end
        check_eq("rsp_data", rspData, exp_data_q.pop_front());
        check_eq("rsp_fault", 32'(rspFault), 32'(exp_fault_q.pop_front()));
        $display("xact wr=%0d w=%0d sg=%0d addr=%h sd=%h -> data=%h fault=%0d lat=%0d",
                 wr, w, sg, a, sd, rspData, rspFault, lat);
        rspReady = 1'b1;
        @(posedge clk); #1;
        rspReady = 1'b0;
        check_eq("rsp_retired", 32'(rspValid), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] sd, input logic ef);
        xact(1'b1, w, 1'b0, a, sd, 32'h0, ef, 0);
        if (!ef) mdl_store(a, w, sd);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] w, input logic sg,
                           input logic [31:0] ed, input logic ef, input int hold);
        xact(1'b0, w, sg, a, 32'h0, ed, ef, hold);
    endtask

    initial begin
        int acc;
        int rsp;
        logic [31:0] ra;
        logic [1:0]  rw;
        logic        rwr;
        logic        rsg;
        logic [31:0] rsd;

        reset = 1'b1; reqValid = 1'b0; reqAddress = 32'h0; reqWrite = 1'b0;
        reqWidth = 2'b00; reqSigned = 1'b0; reqStoreData = 32'h0; rspReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rspValid), 32'd0);
        check_eq("rst_rsp_data", rspData, 32'h0);
        check_eq("rst_rsp_fault", 32'(rspFault), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_req_ready", 32'(reqReady), 32'd1);

        // Sign/zero extension of a byte from a stored word
        do_store(32'h10, 2'b10, 32'hDEAD_BEEF, 1'b0);
        do_load(32'h13, 2'b00, 1'b1, 32'hFFFF_FFDE, 1'b0, 0);
        do_load(32'h13, 2'b00, 1'b0, 32'h0000_00DE, 1'b0, 0);

        // Half store merges into an existing word
        do_store(32'h20, 2'b10, 32'h1122_3344, 1'b0);
        do_store(32'h22, 2'b01, 32'h0000_8001, 1'b0);
        do_load(32'h20, 2'b10, 1'b0, 32'h8001_3344, 1'b0, 0);
        do_load(32'h22, 2'b01, 1'b1, 32'hFFFF_8001, 1'b0, 0);

        // Faults: misaligned, illegal width, out of range; faulting store leaves memory alone
        do_store(32'h04, 2'b10, 32'hCAFE_F00D, 1'b0);
        do_load(32'h06, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        do_store(32'h05, 2'b01, 32'h0000_1234, 1'b1);
        do_load(32'h04, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
        do_load(32'h1000, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        do_store(32'h1000, 2'b10, 32'h5555_5555, 1'b1);
        do_load(32'h0000_0010 | 32'h8000_0000, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        do_load(32'h08, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        do_load(32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);

        // Last word of the array
        do_store(32'hFFC, 2'b10, 32'h0BAD_CAFE, 1'b0);
        do_load(32'hFFC, 2'b10, 1'b0, 32'h0BAD_CAFE, 1'b0, 0);
        do_load(32'hFFE, 2'b01, 1'b1, 32'h0000_0BAD, 1'b0, 0);
        do_load(32'hFFD, 2'b00, 1'b1, 32'hFFFF_FFCA, 1'b0, 0);

        // Backpressure: response held 5 cycles, a reqValid pulse to 0x200 must be ignored
        do_store(32'h200, 2'b10, 32'h1234_5678, 1'b0);
        do_load(32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 5);
        do_load(32'h200, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 0);

        // Back-to-back with rspReady tied high
        acc = 0;
        rsp = 0;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b0; reqWidth = 2'b10; reqSigned = 1'b0;
        reqAddress = 32'h20; rspReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (reqValid && reqReady) acc++;
            if (rspValid) begin
                rsp++;
                check_eq("b2b_data", rspData, 32'h8001_3344);
            end
            @(negedge clk);
        end
        reqValid = 1'b0;
        check_eq("b2b_accepts", 32'(acc), 32'(20 / (EXP_LAT + 1)));
        check_eq("b2b_responses", 32'(rsp), 32'(20 / (EXP_LAT + 1)));
        repeat (EXP_LAT + 2) @(negedge clk);
        rspReady = 1'b0;
        check_eq("b2b_idle", 32'(rspValid), 32'd0);
        $display("xact back-to-back: %0d accepted, %0d responses", acc, rsp);

        // Reset mid-transaction
        do_store(32'h300, 2'b00, 32'h0000_0011, 1'b0);
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqWidth = 2'b00; reqSigned = 1'b0;
        reqAddress = 32'h300; reqStoreData = 32'h0000_00A5;
        @(posedge clk); #1;
        reqValid = 1'b0;
`ifndef DMEM_WAIT_STATES_EN
        // Store already committed when RESP was entered, so it survives the reset
        mdl_store(32'h300, 2'b00, 32'h0000_00A5);
`endif
        reset = 1'b1;
        #1;
        check_eq("midrst_rsp_valid", 32'(rspValid), 32'd0);
        check_eq("midrst_rsp_data", rspData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst_req_ready", 32'(reqReady), 32'd1);
        do_load(32'h300, 2'b00, 1'b0, mdl_load(32'h300, 2'b00, 1'b0), 1'b0, 0);
        $display("xact reset mid-store: byte @300 reads %h", mdl_load(32'h300, 2'b00, 1'b0));

        // Short random run over an initialised window
        for (int i = 0; i < 16; i++) do_store(32'h100 + 32'(i * 4), 2'b10, $urandom, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rw  = 2'($urandom_range(0, 2));
            ra  = 32'h100 + 32'($urandom_range(0, 63));
            if (rw == 2'b01) ra[0] = 1'b0;
            if (rw == 2'b10) ra[1:0] = 2'b00;
            rwr = 1'($urandom);
            rsg = 1'($urandom);
            rsd = $urandom;
            if (rwr) do_store(ra, rw, rsd, 1'b0);
            else     do_load(ra, rw, rsg, mdl_load(ra, rw, rsg), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
